// File: rtl/jtag_dtm_q.sv
// JTAG Debug Transport Module with a DMI request queue, sticky busy/failed
// status, optional DMI response timeout and dmihardreset abort.
module jtag_dtm_q #(
  parameter int unsigned DMI_ADDR_BITS      = 7,
  parameter int unsigned DMI_DATA_BITS      = 32,
  parameter int unsigned DMI_OP_BITS        = 2,
  parameter int unsigned REQ_BITS           = DMI_ADDR_BITS + DMI_DATA_BITS + DMI_OP_BITS,
  parameter int unsigned QUEUE_DEPTH        = 4,
  parameter int unsigned TIMEOUT_CYCLES     = 0,
  parameter logic [2:0]  IDLE_HINT          = 3'h1,
  parameter logic [3:0]  IDCODE_VERSION     = 4'h1,
  parameter logic [15:0] IDCODE_PART_NUMBER = 16'he200,
  parameter logic [10:0] IDCODE_MANUFLD     = 11'h537
) (
  input  logic                jtag_tck_i,
  input  logic                jtag_trst_ni,
  input  logic                tap_req_i,
  input  logic [REQ_BITS-1:0] tap_data_i,
  input  logic                dmireset_i,
  input  logic                dmihardreset_i,
  output logic [REQ_BITS-1:0] dtm_data_o,
  output logic                dtm_valid_o,
  input  logic                dmi_ready_i,
  input  logic [REQ_BITS-1:0] dmi_data_i,
  input  logic                dmi_valid_i,
  output logic                dtm_ready_o,
  output logic [REQ_BITS-1:0] data_o,
  output logic [31:0]         idcode_o,
  output logic [31:0]         dtmcs_o
);

  localparam int unsigned CW    = $clog2(QUEUE_DEPTH) + 1;
  localparam int unsigned PW    = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned TW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned TLAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

  localparam logic [DMI_OP_BITS-1:0] OP_READ   = DMI_OP_BITS'(1);
  localparam logic [DMI_OP_BITS-1:0] OP_WRITE  = DMI_OP_BITS'(2);
  localparam logic [DMI_OP_BITS-1:0] OP_FAILED = DMI_OP_BITS'(2);
  localparam logic [REQ_BITS-1:0]    BUSY_RESP = {{(REQ_BITS-DMI_OP_BITS){1'b0}}, {DMI_OP_BITS{1'b1}}};

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_e;

  state_e                     state_q, state_d;
  logic [REQ_BITS-1:0]        mem_q [QUEUE_DEPTH];
  logic [REQ_BITS-1:0]        mem_d [QUEUE_DEPTH];
  logic [PW-1:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]              count_q, count_d;
  logic [REQ_BITS-1:0]        resp_q, resp_d;
  logic                       stick_busy_q, stick_busy_d;
  logic                       stick_failed_q, stick_failed_d;
  logic [TW-1:0]              timer_q, timer_d;
  logic [DMI_ADDR_BITS-1:0]   inflight_q, inflight_d;

  logic                       req_rw, busy_eff, full, push, pop, outstanding;
  logic [1:0]                 dmistat;
  logic [REQ_BITS-1:0]        head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QUEUE_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign head     = mem_q[rd_ptr_q];
  assign req_rw   = tap_req_i & ((tap_data_i[DMI_OP_BITS-1:0] == OP_READ) |
                                 (tap_data_i[DMI_OP_BITS-1:0] == OP_WRITE));
  // dmireset_i takes effect before a same-cycle request is judged
  assign busy_eff = stick_busy_q & ~dmireset_i;
  assign full     = (count_q == CW'(QUEUE_DEPTH));
  assign push     = req_rw & ~busy_eff & ~full;

  // Next-state for FSM, queue, timer and sticky status
  always_comb begin
    state_d        = state_q;
    mem_d          = mem_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    resp_d         = resp_q;
    stick_busy_d   = busy_eff;
    stick_failed_d = stick_failed_q & ~dmireset_i;
    timer_d        = timer_q;
    inflight_d     = inflight_q;
    pop            = 1'b0;

    if (req_rw && !busy_eff && full) stick_busy_d = 1'b1;

    unique case (state_q)
      S_IDLE: if (count_q != '0) state_d = S_REQ;
      S_REQ: begin
        if (dmi_ready_i) begin
          pop        = 1'b1;
          inflight_d = head[REQ_BITS-1 -: DMI_ADDR_BITS];
          timer_d    = '0;
          state_d    = S_RESP;
        end
      end
      S_RESP: begin
        if (dmi_valid_i) begin
          resp_d = dmi_data_i;
          if (dmi_data_i[DMI_OP_BITS-1:0] == OP_FAILED) stick_failed_d = 1'b1;
          timer_d = '0;
          state_d = S_IDLE;
        end else if (TIMEOUT_CYCLES != 0 && timer_q == TW'(TLAST)) begin
          resp_d         = {inflight_q, {DMI_DATA_BITS{1'b0}}, OP_FAILED};
          stick_failed_d = 1'b1;
          timer_d        = '0;
          state_d        = S_IDLE;
        end else if (TIMEOUT_CYCLES != 0) begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (push) begin
      mem_d[wr_ptr_q] = tap_data_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    count_d = count_q + CW'(push) - CW'(pop);

    // Abort overrides everything, including a same-cycle request
    if (dmihardreset_i) begin
      state_d        = S_IDLE;
      mem_d          = '{default: '0};
      wr_ptr_d       = '0;
      rd_ptr_d       = '0;
      count_d        = '0;
      resp_d         = '0;
      stick_busy_d   = 1'b0;
      stick_failed_d = 1'b0;
      timer_d        = '0;
      inflight_d     = '0;
    end
  end

  // State registers
  always_ff @(posedge jtag_tck_i or negedge jtag_trst_ni) begin
    if (!jtag_trst_ni) begin
      state_q        <= S_IDLE;
      mem_q          <= '{default: '0};
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      resp_q         <= '0;
      stick_busy_q   <= 1'b0;
      stick_failed_q <= 1'b0;
      timer_q        <= '0;
      inflight_q     <= '0;
    end else begin
      state_q        <= state_d;
      mem_q          <= mem_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      resp_q         <= resp_d;
      stick_busy_q   <= stick_busy_d;
      stick_failed_q <= stick_failed_d;
      timer_q        <= timer_d;
      inflight_q     <= inflight_d;
    end
  end

  // Output decode
  assign outstanding = (count_q != '0) | (state_q != S_IDLE);
  assign dmistat     = stick_busy_q ? 2'b11 : (stick_failed_q ? 2'b10 : 2'b00);
  assign dtm_valid_o = (state_q == S_REQ);
  assign dtm_ready_o = (state_q == S_RESP);
  assign dtm_data_o  = head;
  assign data_o      = (stick_busy_q | outstanding | tap_req_i) ? BUSY_RESP :
                       {resp_q[REQ_BITS-1:DMI_OP_BITS],
                        stick_failed_q ? OP_FAILED : resp_q[DMI_OP_BITS-1:0]};
  assign idcode_o    = {IDCODE_VERSION, IDCODE_PART_NUMBER, IDCODE_MANUFLD, 1'b1};
  assign dtmcs_o     = {14'b0, 1'b0, 1'b0, 1'b0, IDLE_HINT, dmistat,
                        6'(DMI_ADDR_BITS), 4'h1};

endmodule

// File: tb/tb_jtag_dtm_q.sv
// Directed bench for jtag_dtm_q: default instance plus an 8-cycle-timeout instance.
module tb_jtag_dtm_q;

  localparam int unsigned RB = 41;
  localparam logic [RB-1:0] BUSY = 41'h3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tap_req = 1'b0, dmireset = 1'b0, dmihardreset = 1'b0;
  logic [RB-1:0] tap_data = '0, dmi_data = '0;
  logic          dmi_ready = 1'b0, dmi_valid = 1'b0;
  logic [RB-1:0] dtm_data, data_o;
  logic          dtm_valid, dtm_ready;
  logic [31:0]   idcode, dtmcs;

  logic          t_tap_req = 1'b0, t_dmireset = 1'b0, t_dmihardreset = 1'b0;
  logic [RB-1:0] t_tap_data = '0, t_dmi_data = '0;
  logic          t_dmi_ready = 1'b0, t_dmi_valid = 1'b0;
  logic [RB-1:0] t_dtm_data, t_data_o;
  logic          t_dtm_valid, t_dtm_ready;
  logic [31:0]   t_idcode, t_dtmcs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jtag_dtm_q u_dut (
    .jtag_tck_i(clk), .jtag_trst_ni(rst_n),
    .tap_req_i(tap_req), .tap_data_i(tap_data),
    .dmireset_i(dmireset), .dmihardreset_i(dmihardreset),
    .dtm_data_o(dtm_data), .dtm_valid_o(dtm_valid), .dmi_ready_i(dmi_ready),
    .dmi_data_i(dmi_data), .dmi_valid_i(dmi_valid), .dtm_ready_o(dtm_ready),
    .data_o(data_o), .idcode_o(idcode), .dtmcs_o(dtmcs)
  );

  jtag_dtm_q #(.TIMEOUT_CYCLES(8)) u_to (
    .jtag_tck_i(clk), .jtag_trst_ni(rst_n),
    .tap_req_i(t_tap_req), .tap_data_i(t_tap_data),
    .dmireset_i(t_dmireset), .dmihardreset_i(t_dmihardreset),
    .dtm_data_o(t_dtm_data), .dtm_valid_o(t_dtm_valid), .dmi_ready_i(t_dmi_ready),
    .dmi_data_i(t_dmi_data), .dmi_valid_i(t_dmi_valid), .dtm_ready_o(t_dtm_ready),
    .data_o(t_data_o), .idcode_o(t_idcode), .dtmcs_o(t_dtmcs)
  );

  function automatic logic [RB-1:0] mk(input logic [6:0] a, input logic [31:0] d,
                                       input logic [1:0] op);
    return {a, d, op};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on u_dut with dmi_ready held high
  task automatic xfer(input string tag, input logic [RB-1:0] req, input logic [RB-1:0] rsp);
    int n;
    tap_req = 1'b1; tap_data = req;
    step();
    tap_req = 1'b0;
    n = 0;
    while (!dtm_valid && n < 10) begin step(); n++; end
    chk({tag, "_valid"}, 64'(dtm_valid), 64'(1));
    chk({tag, "_req"}, 64'(dtm_data), 64'(req));
    step();
    chk({tag, "_rdy"}, 64'(dtm_ready), 64'(1));
    dmi_valid = 1'b1; dmi_data = rsp;
    step();
    dmi_valid = 1'b0;
  endtask

  initial begin
    int n;
    // Reset values
    #3;
    chk("rst_valid", 64'(dtm_valid), 64'(0));
    chk("rst_ready", 64'(dtm_ready), 64'(0));
    chk("rst_dtm_data", 64'(dtm_data), 64'(0));
    chk("rst_data", 64'(data_o), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    chk("idcode", 64'(idcode), 64'h1E200A6F);
    chk("dtmcs", 64'(dtmcs), 64'h00001071);
    chk("t_dtmcs", 64'(t_dtmcs), 64'h00001071);

    // Single write, latency and busy reporting
    dmi_ready = 1'b1;
    tap_req = 1'b1; tap_data = mk(7'h10, 32'hDEADBEEF, 2'd2);
    #1 chk("w_busy_n", 64'(data_o), 64'(BUSY));
    step();
    tap_req = 1'b0;
    chk("w_valid_n1", 64'(dtm_valid), 64'(0));
    chk("w_busy_n1", 64'(data_o), 64'(BUSY));
    step();
    chk("w_valid_n2", 64'(dtm_valid), 64'(1));
    chk("w_req", 64'(dtm_data), 64'(mk(7'h10, 32'hDEADBEEF, 2'd2)));
    step();
    chk("w_rdy", 64'(dtm_ready), 64'(1));
    chk("w_valid_drop", 64'(dtm_valid), 64'(0));
    step(); step();
    chk("w_busy_resp", 64'(data_o), 64'(BUSY));
    dmi_valid = 1'b1; dmi_data = mk(7'h10, 32'hDEADBEEF, 2'd0);
    step();
    dmi_valid = 1'b0;
    chk("w_rdy_drop", 64'(dtm_ready), 64'(0));
    chk("w_data", 64'(data_o), 64'(mk(7'h10, 32'hDEADBEEF, 2'd0)));
    chk("w_dtmcs", 64'(dtmcs), 64'h00001071);

    // Fill queue with ready low, overflow sets busy
    dmi_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tap_req = 1'b1; tap_data = mk(7'(7'h20 + i), 32'h1000 + i, 2'd2);
      step();
    end
    tap_req = 1'b0;
    chk("q_dtmcs_busy", 64'(dtmcs), 64'h00001C71);
    chk("q_data_busy", 64'(data_o), 64'(BUSY));
    chk("q_head", 64'(dtm_data), 64'(mk(7'h20, 32'h1000, 2'd2)));
    dmireset = 1'b1;
    step();
    dmireset = 1'b0;
    chk("q_dtmcs_clr", 64'(dtmcs), 64'h00001071);
    dmi_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!dtm_valid && n < 10) begin step(); n++; end
      chk("q_valid", 64'(dtm_valid), 64'(1));
      chk("q_order", 64'(dtm_data), 64'(mk(7'(7'h20 + i), 32'h1000 + i, 2'd2)));
      step();
      dmi_valid = 1'b1; dmi_data = mk(7'(7'h20 + i), 32'h1000 + i, 2'd0);
      step();
      dmi_valid = 1'b0;
    end
    step(); step();
    chk("q_idle", 64'(dtm_valid), 64'(0));
    chk("q_last", 64'(data_o), 64'(mk(7'h23, 32'h1003, 2'd0)));

    // Failed response is sticky across a later good op
    xfer("f1", mk(7'h05, 32'h0, 2'd1), mk(7'h05, 32'hBAD, 2'd2));
    chk("f_dtmcs", 64'(dtmcs), 64'h00001871);
    chk("f_data", 64'(data_o), 64'(mk(7'h05, 32'hBAD, 2'd2)));
    xfer("f2", mk(7'h06, 32'h600D, 2'd2), mk(7'h06, 32'h600D, 2'd0));
    chk("f_dtmcs2", 64'(dtmcs), 64'h00001871);
    chk("f_data2", 64'(data_o), 64'(mk(7'h06, 32'h600D, 2'd2)));
    dmireset = 1'b1;
    step();
    dmireset = 1'b0;
    chk("f_dtmcs_clr", 64'(dtmcs), 64'h00001071);
    chk("f_data_clr", 64'(data_o), 64'(mk(7'h06, 32'h600D, 2'd0)));

    // Timeout instance: no response ever
    t_dmi_ready = 1'b1;
    t_tap_req = 1'b1; t_tap_data = mk(7'h11, 32'h0, 2'd1);
    step();
    t_tap_req = 1'b0;
    n = 0;
    while (!t_dtm_ready && n < 10) begin step(); n++; end
    n = 0;
    while (t_dtm_ready && n < 20) begin step(); n++; end
    chk("to_cycles", 64'(n), 64'(8));
    chk("to_dtmcs", 64'(t_dtmcs), 64'h00001871);
    chk("to_data", 64'(t_data_o), 64'(mk(7'h11, 32'h0, 2'd2)));

    // Hardreset with first request in flight and two queued
    dmi_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tap_req = 1'b1; tap_data = mk(7'(7'h30 + i), 32'h77 + i, 2'd2);
      step();
    end
    tap_req = 1'b0;
    chk("h_valid", 64'(dtm_valid), 64'(1));
    dmi_ready = 1'b1;
    step();
    dmi_ready = 1'b0;
    chk("h_resp", 64'(dtm_ready), 64'(1));
    dmihardreset = 1'b1;
    step();
    dmihardreset = 1'b0;
    chk("h_valid0", 64'(dtm_valid), 64'(0));
    chk("h_ready0", 64'(dtm_ready), 64'(0));
    chk("h_data0", 64'(data_o), 64'(0));
    chk("h_dtm_data0", 64'(dtm_data), 64'(0));
    dmi_valid = 1'b1; dmi_data = mk(7'h30, 32'hFFFF, 2'd2);
    step();
    dmi_valid = 1'b0;
    step();
    chk("h_late_data", 64'(data_o), 64'(0));
    chk("h_late_dtmcs", 64'(dtmcs), 64'h00001071);
    chk("h_late_valid", 64'(dtm_valid), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
